prio_enc_seq: RTL and testbench

- Parametrised, registered successor to the team's 8-to-3 priority encoder; generalised to N request lines.
- Adds per-line mask, sticky pending capture, a valid/ack grant handshake and registered cascade outputs (gs_n/eo_n).
- Sits between interrupt/request sources and a single consumer (CPU or downstream encoder stage).
- Stages chain through ei_n/eo_n exactly as the discrete 74HC148 parts do.

---
 rtl/prio_enc_seq.sv | 164 ++++++++++++++++
 tb/tb_prio_enc_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_seq.sv
// prio_enc_seq: registered N-line priority encoder with per-line mask, sticky pending
// capture, a valid/ack grant handshake and 74HC148-style cascade outputs (ei_n/gs_n/eo_n).
// Optional build macro PRIO_ENC_ROUND_ROBIN_EN replaces fixed highest-index priority with a
// rotating pointer so the line just served drops to lowest priority.
module prio_enc_seq #(
    parameter int unsigned N              = 8,
    parameter int unsigned W              = $clog2(N),
    parameter bit          REQ_ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ei_n,
    input  logic [N-1:0] req_in,
    input  logic         mask_we,
    input  logic [N-1:0] mask_din,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         gs_n,
    output logic         eo_n,
    output logic [N-1:0] pending
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e       state;
    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] req_active;
    logic [N-1:0] clr_vec;
    logic [N-1:0] pending_d;
    logic [N-1:0] cand, cand_next;
    logic         ack_ok;
    logic [W-1:0] pick_now, pick_next;

    // Request polarity, accepted ack, and next-state pending/candidate vectors
    always_comb begin
        req_active = REQ_ACTIVE_LOW ? ~req_in : req_in;
        ack_ok     = ack & valid;
        clr_vec    = '0;
        if (ack_ok) begin
            clr_vec[code] = 1'b1;
        end
        // Set after clear: a line still requesting on its ack cycle stays pending
        pending_d = (pending & ~clr_vec) | (req_active & ~mask_q);
        mask_d    = mask_we ? mask_din : mask_q;
        cand      = pending & ~mask_q;
        cand_next = pending_d & ~mask_d;
    end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;

    // First candidate scanning downward from start-1, wrapping; start itself is checked last
    function automatic logic [W-1:0] pick_rr(input logic [N-1:0] vec, input logic [W-1:0] start);
        logic [W-1:0] idx;
        logic [W-1:0] jw;
        logic         found;
        int unsigned  j;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            j  = (32'(start) + N - k) % N;
            jw = W'(j);
            if (!found && vec[jw]) begin
                idx   = jw;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign ptr_d     = ack_ok ? code : ptr_q;
    assign pick_now  = pick_rr(cand, ptr_q);
    assign pick_next = pick_rr(cand_next, ptr_d);

    // Rotation pointer follows the most recently accepted code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Highest set index wins
    function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] vec);
        logic [W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[W'(i)]) begin
                idx = W'(i);
            end
        end
        return idx;
    endfunction

    assign pick_now  = pick_fixed(cand);
    assign pick_next = pick_fixed(cand_next);
`endif

    // Mask and sticky pending registers; capture always uses the pre-edge mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '1;
            pending <= '0;
        end else begin
            mask_q  <= mask_d;
            pending <= pending_d;
        end
    end

    // Grant FSM with registered code/valid/gs_n/eo_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            code  <= '0;
            valid <= 1'b0;
            gs_n  <= 1'b1;
            eo_n  <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (!ei_n && (cand != '0)) begin
                        code  <= pick_now;
                        valid <= 1'b1;
                        gs_n  <= 1'b0;
                        eo_n  <= 1'b1;
                        state <= StPresent;
                    end else begin
                        eo_n <= !(!ei_n && (cand_next == '0));
                    end
                end
                StPresent: begin
                    if (ack) begin
                        if (!ei_n && (cand_next != '0)) begin
                            // No bubble: next grant loads on the accepting edge
                            code <= pick_next;
                            eo_n <= 1'b1;
                        end else begin
                            valid <= 1'b0;
                            gs_n  <= 1'b1;
                            eo_n  <= !(!ei_n && (cand_next == '0));
                            state <= StIdle;
                        end
                    end else if (ei_n) begin
                        // Grant withdrawn; pending bit is untouched and re-offered later
                        valid <= 1'b0;
                        gs_n  <= 1'b1;
                        eo_n  <= 1'b1;
                        state <= StIdle;
                    end else begin
                        eo_n <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    valid <= 1'b0;
                    gs_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_enc_seq.sv
// Self-checking bench for prio_enc_seq (N=8, active-low requests). Works with or without
// PRIO_ENC_ROUND_ROBIN_EN; the reference model and rotation expectations follow the macro.
module tb_prio_enc_seq;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ei_n;
    logic [N-1:0] req_in;
    logic         mask_we;
    logic [N-1:0] mask_din;
    logic         ack;
    logic [W-1:0] code;
    logic         valid;
    logic         gs_n;
    logic         eo_n;
    logic [N-1:0] pending;

    int checks = 0;
    int errors = 0;

    prio_enc_seq #(
        .N              (N),
        .W              (W),
        .REQ_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ei_n     (ei_n),
        .req_in   (req_in),
        .mask_we  (mask_we),
        .mask_din (mask_din),
        .ack      (ack),
        .code     (code),
        .valid    (valid),
        .gs_n     (gs_n),
        .eo_n     (eo_n),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [N-1:0] m_pending, m_mask;
    logic         m_valid, m_eo_n;
    int           m_code, m_ptr;

    typedef struct {
        logic [N-1:0] req;
        logic         mwe;
        logic [N-1:0] mdin;
        logic         ack;
        logic [N-1:0] pend;
        logic         valid;
        logic [W-1:0] code;
        logic         eo_n;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Chooses the granted line from a candidate set
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        int i;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
        for (int d = 1; d <= N; d++) begin
            i = (ptr - d + N) % N;
            if (v[W'(i)]) return i;
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            i = k;
            if (v[W'(i)]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_pending = '0;
        m_mask    = '1;
        m_valid   = 1'b0;
        m_code    = 0;
        m_eo_n    = 1'b1;
        m_ptr     = 0;
    endtask

    task automatic check_model();
        chk("valid", 64'(valid), 64'(m_valid));
        chk("gs_n", 64'(gs_n), 64'(!m_valid));
        chk("code", 64'(code), 64'(m_code));
        chk("pending", 64'(pending), 64'(m_pending));
        chk("eo_n", 64'(eo_n), 64'(m_eo_n));
    endtask

    // One clock: apply inputs, advance the model by the stated rules, compare after the edge
    task automatic step(input logic [N-1:0] rq, input logic mwe, input logic [N-1:0] mdin,
                        input logic a, input logic e);
        logic [N-1:0] n_pend, n_mask, c_now, c_nx;
        logic         accepted, n_valid;
        int           n_code, n_ptr;
        req_in   = rq;
        mask_we  = mwe;
        mask_din = mdin;
        ack      = a;
        ei_n     = e;
        accepted = a && m_valid;
        n_pend   = m_pending;
        if (accepted) n_pend[W'(m_code)] = 1'b0;
        n_pend  = n_pend | (~rq & ~m_mask);
        n_mask  = mwe ? mdin : m_mask;
        c_now   = m_pending & ~m_mask;
        c_nx    = n_pend & ~n_mask;
        n_ptr   = accepted ? m_code : m_ptr;
        n_valid = m_valid;
        n_code  = m_code;
        if (!m_valid) begin
            if (!e && c_now != 0) begin
                n_valid = 1'b1;
                n_code  = pick(c_now, m_ptr);
            end
        end else if (a) begin
            if (!e && c_nx != 0) n_code = pick(c_nx, n_ptr);
            else n_valid = 1'b0;
        end else if (e) begin
            n_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pending = n_pend;
        m_mask    = n_mask;
        m_ptr     = n_ptr;
        m_valid   = n_valid;
        m_code    = n_code;
        m_eo_n    = !(!e && c_nx == 0 && !n_valid);
        check_model();
    endtask

    // Asynchronous reset, checked before any clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_gs_n", 64'(gs_n), 64'd1);
        chk("rst_eo_n", 64'(eo_n), 64'd1);
        chk("rst_code", 64'(code), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_code;
        tbl[0]  = '{8'hFF, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{8'hDB, 1'b0, 8'h00, 1'b0, 8'h24, 1'b0, 3'd0, 1'b1};
        tbl[2]  = '{8'hFF, 1'b0, 8'h00, 1'b0, 8'h24, 1'b1, 3'd5, 1'b1};
        tbl[3]  = '{8'hFF, 1'b0, 8'h00, 1'b0, 8'h24, 1'b1, 3'd5, 1'b1};
        tbl[4]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 3'd2, 1'b1};
        tbl[5]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[6]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[7]  = '{8'hFF, 1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[8]  = '{8'h7F, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[9]  = '{8'h7F, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[10] = '{8'h7F, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[11] = '{8'h7F, 1'b0, 8'h00, 1'b0, 8'h80, 1'b0, 3'd2, 1'b1};
        tbl[12] = '{8'hFF, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 3'd7, 1'b1};
        tbl[13] = '{8'hFF, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd7, 1'b0};

        rst_n    = 1'b1;
        ei_n     = 1'b0;
        req_in   = '1;
        mask_we  = 1'b0;
        mask_din = '0;
        ack      = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed table: unmask, two simultaneous requests, back-to-back acks, mask gating
        for (int r = 0; r < 14; r++) begin
            step(tbl[r].req, tbl[r].mwe, tbl[r].mdin, tbl[r].ack, 1'b0);
            chk($sformatf("tbl%0d_pending", r), 64'(pending), 64'(tbl[r].pend));
            chk($sformatf("tbl%0d_valid", r), 64'(valid), 64'(tbl[r].valid));
            chk($sformatf("tbl%0d_code", r), 64'(code), 64'(tbl[r].code));
            chk($sformatf("tbl%0d_eo_n", r), 64'(eo_n), 64'(tbl[r].eo_n));
        end

        // Line 3 held active: each ack re-presents code 3, pending[3] never clears
        step(8'hF7, 1'b0, 8'h00, 1'b0, 1'b0);
        step(8'hF7, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("hold3_first", 64'({valid, code}), 64'({1'b1, 3'd3}));
        for (int i = 0; i < 6; i++) begin
            step(8'hF7, 1'b0, 8'h00, 1'b1, 1'b0);
            chk("hold3_code", 64'({valid, code}), 64'({1'b1, 3'd3}));
            chk("hold3_pend", 64'(pending[3]), 64'd1);
        end
        step(8'hFF, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("hold3_done", 64'({valid, eo_n, pending}), 64'({1'b0, 1'b0, 8'h00}));

        // ei_n withdraws the grant without losing the pending bit; mask_we keeps the grant
        step(8'hEF, 1'b0, 8'h00, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ei_grant", 64'({valid, code}), 64'({1'b1, 3'd4}));
        step(8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ei_withdraw", 64'({valid, gs_n, eo_n, pending}), 64'({1'b0, 1'b1, 1'b1, 8'h10}));
        step(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ei_regrant", 64'({valid, code}), 64'({1'b1, 3'd4}));
        step(8'hFF, 1'b1, 8'h10, 1'b0, 1'b0);
        chk("mask_keeps_grant", 64'({valid, code}), 64'({1'b1, 3'd4}));
        step(8'hFF, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("masked_ack", 64'({valid, pending}), 64'({1'b0, 8'h00}));
        step(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);

        // Reset mid-PRESENT, then all lines pending continuously with ack every cycle
        step(8'hBF, 1'b0, 8'h00, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_reset_valid", 64'(valid), 64'd1);
        do_reset();
        step(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("rot_old_mask", 64'(pending), 64'h00);
        step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rot_first", 64'({valid, code}), 64'({1'b1, 3'd7}));
        for (int k = 1; k <= 8; k++) begin
            step(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef PRIO_ENC_ROUND_ROBIN_EN
            exp_code = (7 - k + 8) % 8;
`else
            exp_code = 7;
`endif
            chk($sformatf("rot_ack%0d", k), 64'({valid, code}), 64'({1'b1, 3'(exp_code)}));
        end

        // Randomised traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step(~(N'($urandom) & N'($urandom) & N'($urandom)),
                 ($urandom_range(0, 15) == 0),
                 N'($urandom) & N'($urandom),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
